// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register writer: register map, frame size and FSM states.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int FRAME_BITS = 16;

    // Bit counter is one wider than needed for 16 so an over-long frame can be told apart.
    localparam int              BIT_CNT_W   = 5;
    localparam logic [BIT_CNT_W-1:0] FRAME_LEN   = BIT_CNT_W'(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_SAT = BIT_CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_writer_if.sv
// Bundle of the SPI pins and the control-register outputs of spi_reg_writer.
interface spi_reg_writer_if;

    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        output wr_strobe,
        output frame_err
    );

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        input  wr_strobe,
        input  frame_err
    );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered rise/fall pulses.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Reset loads the idle level so no spurious edge is seen when reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 write-only slave that loads the five 8-bit control registers read by pwm_peripheral.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_writer_if.slave  bus
);

    logic sclkRise;
    logic ncsLevel;
    logic ncsRise;
    logic ncsFall;
    logic copiLevel;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSclkSync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (bus.sclk),
        .level_o (),
        .rise_o  (sclkRise),
        .fall_o  ()
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uNcsSync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (bus.ncs),
        .level_o (ncsLevel),
        .rise_o  (ncsRise),
        .fall_o  (ncsFall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uCopiSync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (bus.copi),
        .level_o (copiLevel),
        .rise_o  (),
        .fall_o  ()
    );

    state_t                 state_q;
    logic [FRAME_BITS-1:0]  shiftReg_q;
    logic [BIT_CNT_W-1:0]   bitCnt_q;
    logic                   wrStrobe_q;
    logic                   frameErr_q;
    logic [7:0]             enOutLo_q;
    logic [7:0]             enOutHi_q;
    logic [7:0]             enPwmLo_q;
    logic [7:0]             enPwmHi_q;
    logic [7:0]             duty_q;

    logic       frameWrite;
    logic [6:0] frameAddr;
    logic [7:0] frameData;

    assign frameWrite = shiftReg_q[15];
    assign frameAddr  = shiftReg_q[14:8];
    assign frameData  = shiftReg_q[7:0];

    // An sclk edge coinciding with the ncs rise belongs to no frame, so the ncs rise wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            wrStrobe_q <= 1'b0;
            frameErr_q <= 1'b0;
            enOutLo_q  <= 8'h00;
            enOutHi_q  <= 8'h00;
            enPwmLo_q  <= 8'h00;
            enPwmHi_q  <= 8'h00;
            duty_q     <= 8'h00;
        end else begin
            wrStrobe_q <= 1'b0;
            frameErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncsFall) begin
                        bitCnt_q <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ncsRise) begin
                        state_q <= COMMIT;
                    end else if (sclkRise && !ncsLevel) begin
                        shiftReg_q <= {shiftReg_q[FRAME_BITS-2:0], copiLevel};
                        if (bitCnt_q != BIT_CNT_SAT) begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (bitCnt_q != FRAME_LEN) begin
                        frameErr_q <= 1'b1;
                    end else if (frameWrite && (frameAddr <= MAX_ADDR)) begin
                        wrStrobe_q <= 1'b1;
                        case (frameAddr)
                            ADDR_EN_OUT_LO: enOutLo_q <= frameData;
                            ADDR_EN_OUT_HI: enOutHi_q <= frameData;
                            ADDR_EN_PWM_LO: enPwmLo_q <= frameData;
                            ADDR_EN_PWM_HI: enPwmHi_q <= frameData;
                            ADDR_DUTY:      duty_q    <= frameData;
                            default: ;
                        endcase
                    end
                    // A new frame may already be starting while this one is committed.
                    if (ncsFall) begin
                        bitCnt_q <= '0;
                        state_q  <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.en_reg_out_7_0  = enOutLo_q;
    assign bus.en_reg_out_15_8 = enOutHi_q;
    assign bus.en_reg_pwm_7_0  = enPwmLo_q;
    assign bus.en_reg_pwm_15_8 = enPwmHi_q;
    assign bus.pwm_duty_cycle  = duty_q;
    assign bus.wr_strobe       = wrStrobe_q;
    assign bus.frame_err       = frameErr_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: SPI frames at SCLK = clk/8 with hand-computed register values.
module tb_spi_reg_writer;

    localparam int SYNC = 2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   strobeCount;
    int   errCount;
    int   strobeBase;
    int   errBase;

    spi_reg_writer_if bus ();

    spi_reg_writer #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sample away from the active edge.
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) strobeCount++;
        if (bus.frame_err === 1'b1) errCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clockBit(input logic b);
        bus.copi = b;
        waitCycles(4);
        bus.sclk = 1'b1;
        waitCycles(4);
        bus.sclk = 1'b0;
    endtask

    // Sends the first nbits of a left-aligned 17-bit vector, then raises ncs and returns.
    task automatic applyStimulus(input logic [16:0] bits, input int nbits);
        bus.ncs = 1'b0;
        waitCycles(4);
        for (int i = 0; i < nbits; i++) begin
            clockBit(bits[16-i]);
        end
        waitCycles(4);
        bus.ncs = 1'b1;
    endtask

    task automatic markCounts();
        strobeBase = strobeCount;
        errBase    = errCount;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        strobeCount = 0;
        errCount    = 0;
        rst         = 1'b1;
        bus.sclk    = 1'b0;
        bus.copi    = 1'b0;
        bus.ncs     = 1'b1;
        waitCycles(5);
        rst = 1'b0;

        // Reset state and quiet idle.
        waitCycles(100);
        checkOutput("rst_out_lo", 32'(bus.en_reg_out_7_0), 32'h00);
        checkOutput("rst_out_hi", 32'(bus.en_reg_out_15_8), 32'h00);
        checkOutput("rst_pwm_lo", 32'(bus.en_reg_pwm_7_0), 32'h00);
        checkOutput("rst_pwm_hi", 32'(bus.en_reg_pwm_15_8), 32'h00);
        checkOutput("rst_duty", 32'(bus.pwm_duty_cycle), 32'h00);
        checkOutput("idle_strobes", 32'(strobeCount), 32'd0);
        checkOutput("idle_errs", 32'(errCount), 32'd0);

        // Single write with exact latency from the ncs rise.
        markCounts();
        applyStimulus({16'h8055, 1'b0}, 16);
        for (int k = 1; k <= SYNC + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == SYNC + 2) begin
                checkOutput("lat_before", 32'(bus.en_reg_out_7_0), 32'h00);
                checkOutput("strobe_before", 32'(bus.wr_strobe), 32'd0);
            end
            if (k == SYNC + 3) begin
                checkOutput("lat_at", 32'(bus.en_reg_out_7_0), 32'h55);
                checkOutput("strobe_at", 32'(bus.wr_strobe), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("strobe_single", 32'(bus.wr_strobe), 32'd0);
        waitCycles(10);
        checkOutput("w1_strobes", 32'(strobeCount - strobeBase), 32'd1);
        checkOutput("w1_out_hi", 32'(bus.en_reg_out_15_8), 32'h00);
        checkOutput("w1_pwm_lo", 32'(bus.en_reg_pwm_7_0), 32'h00);
        checkOutput("w1_duty", 32'(bus.pwm_duty_cycle), 32'h00);

        // Back-to-back frames with a two-cycle ncs gap.
        markCounts();
        applyStimulus({16'h8480, 1'b0}, 16);
        waitCycles(2);
        applyStimulus({16'h83F0, 1'b0}, 16);
        waitCycles(12);
        checkOutput("b2b_duty", 32'(bus.pwm_duty_cycle), 32'h80);
        checkOutput("b2b_pwm_hi", 32'(bus.en_reg_pwm_15_8), 32'hF0);
        checkOutput("b2b_strobes", 32'(strobeCount - strobeBase), 32'd2);
        checkOutput("b2b_errs", 32'(errCount - errBase), 32'd0);

        // Read frame and out-of-range address are ignored silently.
        markCounts();
        applyStimulus({16'h0412, 1'b0}, 16);
        waitCycles(12);
        applyStimulus({16'h8512, 1'b0}, 16);
        waitCycles(12);
        checkOutput("ign_duty", 32'(bus.pwm_duty_cycle), 32'h80);
        checkOutput("ign_out_lo", 32'(bus.en_reg_out_7_0), 32'h55);
        checkOutput("ign_strobes", 32'(strobeCount - strobeBase), 32'd0);
        checkOutput("ign_errs", 32'(errCount - errBase), 32'd0);

        // Short and long frames are discarded with an error pulse each.
        markCounts();
        applyStimulus({16'h82AA, 1'b0}, 15);
        waitCycles(12);
        applyStimulus({16'h82AA, 1'b1}, 17);
        waitCycles(12);
        checkOutput("len_pwm_lo", 32'(bus.en_reg_pwm_7_0), 32'h00);
        checkOutput("len_errs", 32'(errCount - errBase), 32'd2);
        checkOutput("len_strobes", 32'(strobeCount - strobeBase), 32'd0);

        // Reset in the middle of a frame, then a clean frame.
        markCounts();
        bus.ncs = 1'b0;
        waitCycles(4);
        for (int i = 0; i < 8; i++) begin
            clockBit(1'b1 ^ (i != 0));
        end
        rst      = 1'b1;
        bus.ncs  = 1'b1;
        bus.sclk = 1'b0;
        waitCycles(4);
        rst = 1'b0;
        waitCycles(12);
        checkOutput("mid_rst_out_lo", 32'(bus.en_reg_out_7_0), 32'h00);
        checkOutput("mid_rst_duty", 32'(bus.pwm_duty_cycle), 32'h00);
        markCounts();
        applyStimulus({16'h8033, 1'b0}, 16);
        waitCycles(12);
        checkOutput("post_rst_out_lo", 32'(bus.en_reg_out_7_0), 32'h33);
        checkOutput("post_rst_strobes", 32'(strobeCount - strobeBase), 32'd1);
        checkOutput("post_rst_errs", 32'(errCount - errBase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
